// File: rtl/uart_alu_host_pkg.sv
// Shared definitions for the UART ALU host: FSM state encoding, the ALU
// opcode constants used by both the host and the board-side interface, and
// a helper that sizes the result-wait counter.
package uart_alu_host_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SEND_A   = 4'd1,
    WAIT_A   = 4'd2,
    SEND_B   = 4'd3,
    WAIT_B   = 4'd4,
    SEND_OP  = 4'd5,
    WAIT_OP  = 4'd6,
    WAIT_RES = 4'd7,
    DONE     = 4'd8
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // Counter width able to hold TIMEOUT_CYCLES-1; never narrower than one bit
  // so a degenerate timeout of 1 still yields a legal vector.
  function automatic int count_width(input int cycles);
    if (cycles <= 1) begin
      return 1;
    end
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/uart_alu_host_timeout.sv
// Result-wait cycle counter. Held at zero while clear is high, counts up
// while enabled, and flags expiry on the cycle it holds TIMEOUT_CYCLES-1.
module timeout_counter
  import uart_alu_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = count_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Count up while enabled, saturating at the limit so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/uart_alu_host.sv
// Host-side initiator of the UART ALU protocol. On a start request it sends
// operand A, operand B and the zero-extended opcode, each handshaked by the
// transmitter's done pulse, then waits for one result byte or a timeout.
module uart_alu_host
  import uart_alu_host_pkg::*;
#(
  parameter int N_BITS         = 8,
  parameter int OP_BITS        = 6,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [N_BITS-1:0]  i_dato_A,
  input  logic [N_BITS-1:0]  i_dato_B,
  input  logic [OP_BITS-1:0] i_op,
  input  logic               i_tx_done,
  input  logic               i_rx_done,
  input  logic [N_BITS-1:0]  i_rx_data,
  output logic               o_tx_start,
  output logic [N_BITS-1:0]  o_tx_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [N_BITS-1:0]  o_result
);

  state_t state;
  state_t next_state;

  // Operand A needs no separate capture register: it is loaded straight into
  // o_tx_data on the start edge so the first byte goes out one cycle later.
  logic [N_BITS-1:0]  b_reg;
  logic [OP_BITS-1:0] op_reg;
  logic               capture;

  logic               tx_start_next;
  logic [N_BITS-1:0]  tx_data_next;
  logic [N_BITS-1:0]  result_next;
  logic               err_next;
  logic               done_next;
  logic               busy_next;

  logic               cnt_clear;
  logic               cnt_enable;
  logic               cnt_expired;

  assign capture    = (state == IDLE) && i_start;
  assign cnt_enable = (state == WAIT_RES);
  assign cnt_clear  = !cnt_enable;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (i_clk),
    .rst_n   (i_reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latch operand B and the opcode only when a request is accepted in IDLE.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      b_reg  <= '0;
      op_reg <= '0;
    end else if (capture) begin
      b_reg  <= i_dato_B;
      op_reg <= i_op;
    end
  end

  // Next-state and next-output decode; every output is registered below
  // from these values so nothing combinational leaves the block.
  always_comb begin
    next_state   = state;
    tx_data_next = o_tx_data;
    result_next  = o_result;
    err_next     = o_err;
    case (state)
      IDLE: begin
        if (i_start) begin
          next_state   = SEND_A;
          tx_data_next = i_dato_A;
        end
      end
      SEND_A:  next_state = WAIT_A;
      WAIT_A: begin
        if (i_tx_done) begin
          next_state   = SEND_B;
          tx_data_next = b_reg;
        end
      end
      SEND_B:  next_state = WAIT_B;
      WAIT_B: begin
        if (i_tx_done) begin
          next_state   = SEND_OP;
          tx_data_next = N_BITS'(op_reg);
        end
      end
      SEND_OP: next_state = WAIT_OP;
      WAIT_OP: begin
        if (i_tx_done) begin
          next_state = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (i_rx_done) begin
          next_state  = DONE;
          result_next = i_rx_data;
          err_next    = 1'b0;
        end else if (cnt_expired) begin
          next_state  = DONE;
          result_next = '0;
          err_next    = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    tx_start_next = (next_state == SEND_A) || (next_state == SEND_B) ||
                    (next_state == SEND_OP);
    done_next     = (next_state == DONE);
    busy_next     = (next_state != IDLE);
  end

  // Output registers, loaded from the decoded next values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_result   <= '0;
    end else begin
      o_tx_start <= tx_start_next;
      o_tx_data  <= tx_data_next;
      o_busy     <= busy_next;
      o_done     <= done_next;
      o_err      <= err_next;
      o_result   <= result_next;
    end
  end

endmodule

// File: tb/tb_uart_alu_host.sv
// Directed testbench for uart_alu_host with a short result timeout.
module tb_uart_alu_host;
  import uart_alu_host_pkg::*;

  logic       i_clk;
  logic       i_reset;
  logic       i_start;
  logic [7:0] i_dato_A;
  logic [7:0] i_dato_B;
  logic [5:0] i_op;
  logic       i_tx_done;
  logic       i_rx_done;
  logic [7:0] i_rx_data;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [7:0] o_result;

  int n_compared;
  int n_mismatched;

  uart_alu_host #(
    .N_BITS(8),
    .OP_BITS(6),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_dato_A   (i_dato_A),
    .i_dato_B   (i_dato_B),
    .i_op       (i_op),
    .i_tx_done  (i_tx_done),
    .i_rx_done  (i_rx_done),
    .i_rx_data  (i_rx_data),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_result   (o_result)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Inputs change and outputs are observed on the falling edge.
  task automatic step();
    @(negedge i_clk);
  endtask

  // One-cycle transmitter acknowledge; caller must be in a WAIT_x state.
  task automatic send_ack();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
  endtask

  // Present a request for one cycle; on return the DUT is in SEND_A.
  task automatic start_req(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    i_dato_A = a;
    i_dato_B = b;
    i_op     = op;
    i_start  = 1'b1;
    step();
    i_start  = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_start = 1'b0; i_dato_A = '0; i_dato_B = '0; i_op = '0;
    i_tx_done = 1'b0; i_rx_done = 1'b0; i_rx_data = '0;
    step(); step();
    n_compared++; if (o_tx_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_tx_start: got %b want 0", o_tx_start); end
    n_compared++; if (o_tx_data !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_tx_data: got %h want 00", o_tx_data); end
    n_compared++; if (o_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", o_busy); end
    n_compared++; if (o_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %b want 0", o_done); end
    n_compared++; if (o_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_err: got %b want 0", o_err); end
    n_compared++; if (o_result !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_result: got %h want 00", o_result); end
    i_reset = 1'b1;
    step();
    n_compared++; if (o_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_idle_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_add();
    start_req(8'h05, 8'h03, OP_ADD);
    i_dato_A = 8'hEE; i_dato_B = 8'hDD; i_op = OP_SUB;
    n_compared++; if (o_tx_start !== 1'b1) begin n_mismatched++; $display("[TB] FAIL add_start_a: got %b want 1", o_tx_start); end
    n_compared++; if (o_tx_data !== 8'h05) begin n_mismatched++; $display("[TB] FAIL add_byte_a: got %h want 05", o_tx_data); end
    n_compared++; if (o_busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL add_busy: got %b want 1", o_busy); end
    step();
    n_compared++; if (o_tx_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL add_start_pulse: got %b want 0", o_tx_start); end
    step(); step();
    n_compared++; if (o_tx_data !== 8'h05) begin n_mismatched++; $display("[TB] FAIL add_hold_a: got %h want 05", o_tx_data); end
    send_ack();
    n_compared++; if (o_tx_start !== 1'b1) begin n_mismatched++; $display("[TB] FAIL add_start_b: got %b want 1", o_tx_start); end
    n_compared++; if (o_tx_data !== 8'h03) begin n_mismatched++; $display("[TB] FAIL add_byte_b: got %h want 03", o_tx_data); end
    step(); send_ack();
    n_compared++; if (o_tx_start !== 1'b1) begin n_mismatched++; $display("[TB] FAIL add_start_op: got %b want 1", o_tx_start); end
    n_compared++; if (o_tx_data !== 8'h20) begin n_mismatched++; $display("[TB] FAIL add_byte_op: got %h want 20", o_tx_data); end
    step(); send_ack();
    n_compared++; if (o_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL add_wait_done: got %b want 0", o_done); end
    i_rx_data = 8'h08; i_rx_done = 1'b1;
    step();
    i_rx_done = 1'b0;
    n_compared++; if (o_done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL add_done: got %b want 1", o_done); end
    n_compared++; if (o_result !== 8'h08) begin n_mismatched++; $display("[TB] FAIL add_result: got %h want 08", o_result); end
    n_compared++; if (o_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL add_err: got %b want 0", o_err); end
    step();
    n_compared++; if (o_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL add_done_pulse: got %b want 0", o_done); end
    n_compared++; if (o_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL add_idle_busy: got %b want 0", o_busy); end
    n_compared++; if (o_result !== 8'h08) begin n_mismatched++; $display("[TB] FAIL add_result_hold: got %h want 08", o_result); end
  endtask

  task automatic test_timeout();
    int cycles;
    start_req(8'h12, 8'h34, OP_SUB);
    step(); send_ack();
    step(); send_ack();
    n_compared++; if (o_tx_data !== 8'h22) begin n_mismatched++; $display("[TB] FAIL to_byte_op: got %h want 22", o_tx_data); end
    step(); send_ack();
    cycles = 0;
    for (int k = 1; k <= 150; k++) begin
      step();
      if (o_done === 1'b1) begin
        cycles = k;
        break;
      end
    end
    n_compared++; if (cycles !== 100) begin n_mismatched++; $display("[TB] FAIL to_latency: got %0d cycles want 100", cycles); end
    n_compared++; if (o_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL to_err: got %b want 1", o_err); end
    n_compared++; if (o_result !== 8'h00) begin n_mismatched++; $display("[TB] FAIL to_result: got %h want 00", o_result); end
    step();
    n_compared++; if (o_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL to_done_pulse: got %b want 0", o_done); end
    n_compared++; if (o_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL to_err_hold: got %b want 1", o_err); end
  endtask

  task automatic test_timeout_tie();
    start_req(8'h01, 8'h02, OP_AND);
    step(); send_ack();
    step(); send_ack();
    step(); send_ack();
    repeat (99) step();
    n_compared++; if (o_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL tie_early_done: got %b want 0", o_done); end
    i_rx_data = 8'hAA; i_rx_done = 1'b1;
    step();
    i_rx_done = 1'b0;
    n_compared++; if (o_done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL tie_done: got %b want 1", o_done); end
    n_compared++; if (o_result !== 8'hAA) begin n_mismatched++; $display("[TB] FAIL tie_result: got %h want aa", o_result); end
    n_compared++; if (o_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL tie_err: got %b want 0", o_err); end
    step();
  endtask

  task automatic test_ignore();
    logic seen;
    i_tx_done = 1'b1; i_rx_done = 1'b1; i_rx_data = 8'h99;
    step();
    i_tx_done = 1'b0; i_rx_done = 1'b0;
    n_compared++; if (o_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ign_idle_busy: got %b want 0", o_busy); end
    n_compared++; if (o_result !== 8'hAA) begin n_mismatched++; $display("[TB] FAIL ign_idle_rx: got %h want aa", o_result); end
    start_req(8'h11, 8'h22, OP_XOR);
    n_compared++; if (o_tx_data !== 8'h11) begin n_mismatched++; $display("[TB] FAIL ign_byte_a: got %h want 11", o_tx_data); end
    step();
    i_rx_data = 8'h55; i_rx_done = 1'b1;
    step();
    i_rx_done = 1'b0;
    n_compared++; if (o_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ign_stray_done: got %b want 0", o_done); end
    n_compared++; if (o_tx_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ign_stray_tx: got %b want 0", o_tx_start); end
    send_ack();
    n_compared++; if (o_tx_data !== 8'h22) begin n_mismatched++; $display("[TB] FAIL ign_byte_b: got %h want 22", o_tx_data); end
    step();
    i_dato_A = 8'h66; i_dato_B = 8'h77; i_op = OP_NOR; i_start = 1'b1;
    step();
    i_start = 1'b0;
    n_compared++; if (o_tx_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ign_restart_tx: got %b want 0", o_tx_start); end
    n_compared++; if (o_tx_data !== 8'h22) begin n_mismatched++; $display("[TB] FAIL ign_restart_data: got %h want 22", o_tx_data); end
    send_ack();
    n_compared++; if (o_tx_data !== 8'h26) begin n_mismatched++; $display("[TB] FAIL ign_byte_op: got %h want 26", o_tx_data); end
    step(); send_ack();
    repeat (5) step();
    n_compared++; if (o_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ign_wait_done: got %b want 0", o_done); end
    n_compared++; if (o_result !== 8'hAA) begin n_mismatched++; $display("[TB] FAIL ign_wait_result: got %h want aa", o_result); end
    i_rx_data = 8'h3C; i_rx_done = 1'b1;
    step();
    i_rx_done = 1'b0;
    n_compared++; if (o_result !== 8'h3C) begin n_mismatched++; $display("[TB] FAIL ign_result: got %h want 3c", o_result); end
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      seen = seen | o_tx_start | o_busy;
    end
    n_compared++; if (seen !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ign_no_queue: got %b want 0", seen); end
  endtask

  task automatic test_reset_mid();
    start_req(8'h33, 8'h44, OP_AND);
    step(); send_ack();
    step(); send_ack();
    step();
    n_compared++; if (o_tx_data !== 8'h24) begin n_mismatched++; $display("[TB] FAIL rst_pre_data: got %h want 24", o_tx_data); end
    #2 i_reset = 1'b0;
    #1;
    n_compared++; if (o_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_busy: got %b want 0", o_busy); end
    n_compared++; if (o_tx_data !== 8'h00) begin n_mismatched++; $display("[TB] FAIL rst_tx_data: got %h want 00", o_tx_data); end
    n_compared++; if (o_result !== 8'h00) begin n_mismatched++; $display("[TB] FAIL rst_result: got %h want 00", o_result); end
    n_compared++; if (o_tx_start !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_flags: got %b%b%b want 000", o_tx_start, o_done, o_err); end
    step();
    i_reset = 1'b1;
    start_req(8'hF0, 8'h0F, OP_OR);
    n_compared++; if (o_tx_start !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_new_start: got %b want 1", o_tx_start); end
    n_compared++; if (o_tx_data !== 8'hF0) begin n_mismatched++; $display("[TB] FAIL rst_byte_a: got %h want f0", o_tx_data); end
    step(); send_ack();
    n_compared++; if (o_tx_data !== 8'h0F) begin n_mismatched++; $display("[TB] FAIL rst_byte_b: got %h want 0f", o_tx_data); end
    step(); send_ack();
    n_compared++; if (o_tx_data !== 8'h25) begin n_mismatched++; $display("[TB] FAIL rst_byte_op: got %h want 25", o_tx_data); end
    step(); send_ack();
    i_rx_data = 8'hFF; i_rx_done = 1'b1;
    step();
    i_rx_done = 1'b0;
    n_compared++; if (o_done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_done: got %b want 1", o_done); end
    n_compared++; if (o_result !== 8'hFF) begin n_mismatched++; $display("[TB] FAIL rst_result_ff: got %h want ff", o_result); end
    n_compared++; if (o_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_err: got %b want 0", o_err); end
    step();
  endtask

  // Run every scenario in order, then report.
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_add();
    test_timeout();
    test_timeout_tie();
    test_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
